i2c_target: RTL
===============

Name: i2c_target

Overview:
- I2C responder (slave) that terminates transactions issued by `i2c_controller` and exposes a byte-wide register-file port to the PWM core.
- Samples SCL/SDA with the system clock and decodes START, STOP and repeated START.
- Supports a register-pointer write, data writes, and data reads via repeated START.
- Drives SDA open-drain only: it can pull low or release, never drive high.

Parameters:
- ADDRESS, 7'h78, 7-bit target address to match.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk_i  input  1  system clock; must run at least 16x the SCL frequency.
- rst_i  input  1  asynchronous active-high reset.
- scl_i  input  1  SCL pin sample.
- sda_i  input  1  SDA pin sample.
- sda_oe_o  output  1  1 = pull SDA low; 0 = release.
- reg_addr_o  output  8  register pointer.
- reg_wdata_o  output  8  write data.
- reg_we_o  output  1  one-cycle write strobe.
- reg_rdata_i  input  8  read data for reg_addr_o; valid combinationally within 1 clk.
- busy_o  output  1  high from address match until STOP or NACK end.

Behaviour:
- Reset: sda_oe_o=0, reg_addr_o=0, reg_wdata_o=0, reg_we_o=0, busy_o=0, state IDLE. Reset asserted mid-transfer releases SDA immediately, with no partial write.
- Inputs pass through SYNC_STAGES flops plus one history flop. Edge and condition detection therefore lags the pins by SYNC_STAGES+1 clk.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- START is honoured in any state, including mid-byte. It clears the bit counter and enters ADDR; this is how repeated START works. STOP in any state returns to IDLE and clears busy_o.
- Data bits are sampled on SCL rising edges, MSB first. The target changes SDA only after SCL falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - On match: after the 8th SCL fall, set sda_oe_o=1 and busy_o=1, then go to ACK_A.
    - On mismatch: go to WAIT_STOP, leaving SDA released (NACK).
  - ACK_A: at the 9th SCL fall, release SDA.
    - R/W=0: go to REG.
    - R/W=1: latch reg_rdata_i into the shift register, drive its bit 7 (sda_oe_o = ~bit), go to RDATA.
  - REG: shift 8 bits into reg_addr_o. ACK as above, then go to WDATA.
  - WDATA: shift 8 bits.
    - After the 8th rising edge, load reg_wdata_o.
    - Pulse reg_we_o for exactly 1 clk on the following SCL fall, while simultaneously asserting ACK.
    - After the ACK fall, apply the pointer rule (Optional Feature) and stay in WDATA for the next byte.
  - RDATA: shift out on each SCL fall.
    - After the 8th bit, release SDA.
    - Sample the controller's ACK on the 9th rising edge.
    - ACK=0: apply the pointer rule, reload from reg_rdata_i, and continue.
    - NACK: release SDA, clear busy_o, go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- reg_addr_o increments modulo 256 (0xFF wraps to 0x00).
- sda_oe_o is never asserted while SCL is high, except to hold an ACK or data bit across its high phase.

Optional Feature:
- Macro I2C_TARGET_AUTO_INC_EN.
- When defined: reg_addr_o increments by 1 after every ACKed write data byte and every controller-ACKed read byte, enabling burst access.
- When undefined: reg_addr_o changes only in REG state. Bursts repeatedly access the same register.

Test Plan:
- Write 0x78/W, reg 0x0F, data 0x55, STOP -> three ACKs; one reg_we_o pulse with reg_addr_o=0x0F and reg_wdata_o=0x55; busy_o falls after STOP.
- Address 0x22/W -> SDA stays released on the 9th clock (NACK), no reg_we_o, busy_o stays 0 until STOP.
- Write 0x78/W reg 0x0F, repeated START, 0x78/R with reg_rdata_i=0xA5, controller NACK -> bits 10100101 on SDA, busy_o=0 after NACK, no write strobe.
- With I2C_TARGET_AUTO_INC_EN: reg 0xFE, data 0x11, 0x22, 0x33 -> writes land at 0xFE, 0xFF, 0x00. Without the macro: all three writes land at 0xFE.
- rst_i pulsed during the 4th data bit of a write -> sda_oe_o=0 within the same cycle, outputs at reset values, no reg_we_o; the next full transaction succeeds.
- STOP issued after 3 bits of a data byte -> no reg_we_o, state IDLE, busy_o=0.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C responder that maps bus transactions onto a byte-wide register port.
// Ports: clk_i/rst_i (async active-high reset), scl_i/sda_i pin samples, sda_oe_o open-drain
// pull-low, reg_addr_o/reg_wdata_o/reg_we_o/reg_rdata_i register port, busy_o transfer active.
// Optional: define I2C_TARGET_AUTO_INC_EN to step reg_addr_o after each acknowledged data byte.
module i2c_target #(
   parameter logic [6:0] ADDRESS     = 7'h78,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic [7:0] reg_addr_o,
   output logic [7:0] reg_wdata_o,
   output logic       reg_we_o,
   input  logic [7:0] reg_rdata_i,
   output logic       busy_o
);
`ifdef I2C_TARGET_AUTO_INC_EN
   localparam logic [7:0] STEP = 8'd1;
`else
   localparam logic [7:0] STEP = 8'd0;
`endif
   typedef enum logic [3:0] {IDLE, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, RDATA, RACK, WAIT_STOP} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl, sda, scl_d, sda_d, rise, fall, start, stop;
   logic [3:0] cnt, cnt_n;
   logic [7:0] sr, sr_n, addr_n, wdata_n;
   logic oe_n, busy_n, we_n;
   assign scl   = scl_sync[SYNC_STAGES-1];
   assign sda   = sda_sync[SYNC_STAGES-1];
   assign rise  = scl & ~scl_d;
   assign fall  = ~scl & scl_d;
   assign start = scl & scl_d & sda_d & ~sda;
   assign stop  = scl & scl_d & ~sda_d & sda;
   // Synchronizers reset to the idle bus level so reset never fakes an edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_d    <= scl;
         sda_d    <= sda;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         sr          <= '0;
         sda_oe_o    <= 1'b0;
         busy_o      <= 1'b0;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
         reg_we_o    <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         sr          <= sr_n;
         sda_oe_o    <= oe_n;
         busy_o      <= busy_n;
         reg_addr_o  <= addr_n;
         reg_wdata_o <= wdata_n;
         reg_we_o    <= we_n;
      end
   end
   // cnt counts SCL rising edges within a byte; every SDA change happens on an SCL fall.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sr_n    = sr;
      oe_n    = sda_oe_o;
      busy_n  = busy_o;
      addr_n  = reg_addr_o;
      wdata_n = reg_wdata_o;
      we_n    = 1'b0;
      if (start) begin
         state_n = ADDR;
         cnt_n   = '0;
         oe_n    = 1'b0;
      end else if (stop) begin
         state_n = IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         case (state)
            ADDR, REG, WDATA: begin
               if (rise && cnt != 4'd8) begin
                  sr_n  = {sr[6:0], sda};
                  cnt_n = cnt + 4'd1;
               end
               if (rise && cnt == 4'd7 && state == WDATA) wdata_n = {sr[6:0], sda};
               if (fall && cnt == 4'd8) begin
                  cnt_n = '0;
                  oe_n  = 1'b1;
                  if (state == ADDR) begin
                     state_n = (sr[7:1] == ADDRESS) ? ACK_A : WAIT_STOP;
                     oe_n    = (sr[7:1] == ADDRESS);
                     busy_n  = (sr[7:1] == ADDRESS);
                  end else if (state == REG) begin
                     addr_n  = sr;
                     state_n = ACK_R;
                  end else begin
                     we_n    = 1'b1;
                     state_n = ACK_W;
                  end
               end
            end
            ACK_A: begin
               if (fall) begin
                  // sr[0] still holds the R/W bit of the address byte.
                  sr_n    = sr[0] ? reg_rdata_i : sr;
                  oe_n    = sr[0] & ~reg_rdata_i[7];
                  state_n = sr[0] ? RDATA : REG;
               end
            end
            ACK_R: begin
               if (fall) begin
                  oe_n    = 1'b0;
                  state_n = WDATA;
               end
            end
            ACK_W: begin
               if (fall) begin
                  oe_n    = 1'b0;
                  addr_n  = reg_addr_o + STEP;
                  state_n = WDATA;
               end
            end
            RDATA: begin
               if (rise) cnt_n = cnt + 4'd1;
               if (fall) begin
                  sr_n    = {sr[6:0], 1'b0};
                  oe_n    = (cnt == 4'd8) ? 1'b0 : ~sr[6];
                  state_n = (cnt == 4'd8) ? RACK : RDATA;
               end
            end
            RACK: begin
               if (rise) begin
                  state_n = sda ? WAIT_STOP : RACK;
                  busy_n  = ~sda;
                  addr_n  = sda ? reg_addr_o : reg_addr_o + STEP;
               end
               // Reload after the pointer has settled so the next byte reads the new register.
               if (fall) begin
                  sr_n    = reg_rdata_i;
                  oe_n    = ~reg_rdata_i[7];
                  cnt_n   = '0;
                  state_n = RDATA;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
